dma_write_irq_ctrl: RTL

Parametrised interrupt controller for the DMA write engine. It generalises the single-source D/Q interrupt stage to NUM_SRC sources. Adds per-source enable, sticky pending bits with write-1-to-clear, selectable level/pulse output, event coalescing with a timeout, and a saturating event counter. Sits between the DMA write datapath status pulses and the PS interrupt line, with control and status exposed through the AXI-Lite register slice.

---
 rtl/dma_write_irq_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/dma_write_irq_ctrl.sv
// -----------------------------------------------------------------------------
// dma_write_irq_ctrl
// Interrupt controller for the DMA write engine. Collects rising edges from
// NUM_SRC status sources into sticky pending bits, coalesces accepted events
// against a threshold (with an optional timeout) and drives a single
// interrupt line to the PS in either level or fixed-width pulse form.
//
// Ports:
//   M_AXI_ACLK     clock
//   M_AXI_ARESETN  asynchronous active-low reset
//   irq_src        raw event inputs (synchronous)
//   irq_enable     per-source enable
//   irq_clear      write-1-to-clear strobes for the pending bits
//   irq_mode       0 = level output, 1 = pulse output (latched on fire)
//   coal_count     events needed before firing (0 behaves as 1)
//   coal_timeout   clocks in ACCUM before a forced fire (0 = no timeout)
//   irq_pending    sticky pending status
//   irq_out        interrupt to the PS
//   event_count    saturating total of accepted events
// -----------------------------------------------------------------------------
module dma_write_irq_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int PULSE_WIDTH = 4,
    parameter int COAL_WIDTH  = 8
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESETN,
    input  logic [NUM_SRC-1:0]    irq_src,
    input  logic [NUM_SRC-1:0]    irq_enable,
    input  logic [NUM_SRC-1:0]    irq_clear,
    input  logic                  irq_mode,
    input  logic [COAL_WIDTH-1:0] coal_count,
    input  logic [15:0]           coal_timeout,
    output logic [NUM_SRC-1:0]    irq_pending,
    output logic                  irq_out,
    output logic [15:0]           event_count
);

    localparam int CNT_W = $clog2(NUM_SRC + 1);
    localparam int SUM_W = COAL_WIDTH + CNT_W;
    localparam int PW_W  = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam logic [PW_W-1:0]       PW_LAST = PW_W'(PULSE_WIDTH - 1);
    localparam logic [COAL_WIDTH-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FIRE  = 2'd2
    } state_t;

    // Number of set bits in an event vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_SRC-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    logic [NUM_SRC-1:0]    src_d_r;
    logic [NUM_SRC-1:0]    pend_r;
    logic [15:0]           event_count_r;
    state_t                state_r;
    logic [COAL_WIDTH-1:0] acc_r;
    logic [15:0]           timer_r;
    logic [PW_W-1:0]       pulse_cnt_r;
    logic                  mode_r;
    logic                  irq_out_r;

    logic [NUM_SRC-1:0]    acc_ev_s;
    logic [NUM_SRC-1:0]    pend_nx_s;
    logic [CNT_W-1:0]      n_s;
    logic                  active_r_s;
    logic                  active_nx_s;
    logic [COAL_WIDTH-1:0] thr_s;
    logic [SUM_W-1:0]      sum_s;
    logic                  thr_met_s;
    logic [COAL_WIDTH-1:0] acc_sat_s;
    logic [16:0]           timer_inc_s;
    logic                  timeout_s;
    logic [16:0]           ev_sum_s;

    assign acc_ev_s    = irq_src & ~src_d_r & irq_enable;
    assign n_s         = popcount(acc_ev_s);
    // A new set on the same bit as a clear wins.
    assign pend_nx_s   = (pend_r & ~irq_clear) | acc_ev_s;
    // Level FIRE holds on the registered pending; ACCUM looks at post-clear state.
    assign active_r_s  = |(pend_r & irq_enable);
    assign active_nx_s = |(pend_nx_s & irq_enable);
    assign thr_s       = (coal_count == '0) ? COAL_WIDTH'(1) : coal_count;
    assign sum_s       = SUM_W'(acc_r) + SUM_W'(n_s);
    assign thr_met_s   = (sum_s >= SUM_W'(thr_s));
    assign acc_sat_s   = (sum_s > SUM_W'(ACC_MAX)) ? ACC_MAX : sum_s[COAL_WIDTH-1:0];
    assign timer_inc_s = {1'b0, timer_r} + 17'd1;
    assign timeout_s   = (coal_timeout != 16'd0) && (timer_inc_s == {1'b0, coal_timeout});
    assign ev_sum_s    = {1'b0, event_count_r} + 17'(n_s);

    // Edge-detect history, sticky pending bits and saturating event counter.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            src_d_r       <= '0;
            pend_r        <= '0;
            event_count_r <= 16'd0;
        end else begin
            src_d_r       <= irq_src;
            pend_r        <= pend_nx_s;
            event_count_r <= ev_sum_s[16] ? 16'hFFFF : ev_sum_s[15:0];
        end
    end

    // Coalescing / firing state machine with registered interrupt output.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_r     <= ST_IDLE;
            acc_r       <= '0;
            timer_r     <= 16'd0;
            pulse_cnt_r <= '0;
            mode_r      <= 1'b0;
            irq_out_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (n_s != '0) begin
                        if (thr_met_s) begin
                            state_r     <= ST_FIRE;
                            acc_r       <= '0;
                            mode_r      <= irq_mode;
                            pulse_cnt_r <= '0;
                            irq_out_r   <= 1'b1;
                        end else begin
                            state_r   <= ST_ACCUM;
                            acc_r     <= acc_sat_s;
                            timer_r   <= 16'd0;
                            irq_out_r <= 1'b0;
                        end
                    end else begin
                        irq_out_r <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    timer_r <= timer_inc_s[15:0];
                    if (thr_met_s || timeout_s) begin
                        state_r     <= ST_FIRE;
                        acc_r       <= '0;
                        mode_r      <= irq_mode;
                        pulse_cnt_r <= '0;
                        irq_out_r   <= 1'b1;
                    end else if (!active_nx_s) begin
                        state_r   <= ST_IDLE;
                        acc_r     <= '0;
                        irq_out_r <= 1'b0;
                    end else begin
                        acc_r     <= acc_sat_s;
                        irq_out_r <= 1'b0;
                    end
                end
                ST_FIRE: begin
                    if (mode_r) begin
                        if (pulse_cnt_r == PW_LAST) begin
                            // Leaving always gives at least one low clock.
                            irq_out_r <= 1'b0;
                            if (acc_sat_s != '0) begin
                                state_r <= ST_ACCUM;
                                acc_r   <= acc_sat_s;
                                timer_r <= 16'd0;
                            end else begin
                                state_r <= ST_IDLE;
                                acc_r   <= '0;
                            end
                        end else begin
                            pulse_cnt_r <= pulse_cnt_r + PW_W'(1);
                            acc_r       <= acc_sat_s;
                            irq_out_r   <= 1'b1;
                        end
                    end else begin
                        if (active_r_s) begin
                            acc_r     <= acc_sat_s;
                            irq_out_r <= 1'b1;
                        end else begin
                            state_r   <= ST_IDLE;
                            acc_r     <= '0;
                            irq_out_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    acc_r     <= '0;
                    irq_out_r <= 1'b0;
                end
            endcase
        end
    end

    assign irq_pending = pend_r;
    assign irq_out     = irq_out_r;
    assign event_count = event_count_r;

endmodule
